// File: rtl/ahb_master_if.sv
// ahb_master_if: turns one master request into a single AHB transfer
// (SINGLE burst, WORD size, non-pipelined). The sequence is bus request,
// then address phase, then data phase. Every output comes from a flop.
// The bus-side values are precomputed from the next state and the next
// capture contents.
module ahb_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  // master side
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            slv_sel_in,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr,
  input  logic                  enable,
  input  logic                  hbusreq_in,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  done,
  output logic                  err,
  output logic                  busy,
  // arbiter
  output logic                  hbusreq,
  input  logic                  hgrant,
  // AHB bus
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [DATA_WIDTH-1:0] hwdata,
  output logic [1:0]            slv_sel,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hready,
  input  logic [1:0]            hresp
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ADDR, S_DATA} state_t;

  // request latched in IDLE; master inputs are ignored until the next IDLE
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  wr;
    logic [1:0]            slv;
  } req_t;

  state_t                state, state_nx;
  req_t                  cap, cap_nx;
  logic [DATA_WIDTH-1:0] dout_nx, hwdata_nx;
  logic [ADDR_WIDTH-1:0] haddr_nx;
  logic [1:0]            htrans_nx, slv_sel_nx;
  logic                  done_nx, err_nx, busy_nx, hbusreq_nx, hwrite_nx;

  // transfer size and burst type never change
  assign hsize  = 3'b010;
  assign hburst = 3'b000;

  // next state, capture, and the registered output values for that state
  always_comb begin
    state_nx   = state;
    cap_nx     = cap;
    dout_nx    = dout;
    err_nx     = err;
    done_nx    = 1'b0;
    haddr_nx   = haddr;
    hwrite_nx  = hwrite;
    slv_sel_nx = slv_sel;
    case (state)
      S_IDLE: if (enable && hbusreq_in) begin
        cap_nx.addr = addr;
        cap_nx.data = din;
        cap_nx.wr   = wr;
        cap_nx.slv  = slv_sel_in;
        state_nx    = S_REQ;
      end
      S_REQ:  if (hgrant && hready) state_nx = S_ADDR;
      // grant loss from here on is ignored; the transfer always finishes
      S_ADDR: if (hready) state_nx = S_DATA;
      S_DATA: if (hready) begin
        state_nx = S_IDLE;
        done_nx  = 1'b1;
        // any non-OKAY response ends the transfer as an error, with no re-issue
        err_nx   = (hresp != RESP_OKAY);
        if (!cap.wr) dout_nx = hrdata;
      end
      default: state_nx = S_IDLE;
    endcase
    busy_nx    = (state_nx != S_IDLE);
    hbusreq_nx = (state_nx == S_REQ);
    htrans_nx  = (state_nx == S_ADDR) ? TR_NONSEQ : TR_IDLE;
    // address/control load on entry to ADDR and hold through DATA and beyond
    if (state_nx == S_ADDR) begin
      haddr_nx   = cap_nx.addr;
      hwrite_nx  = cap_nx.wr;
      slv_sel_nx = cap_nx.slv;
    end
    hwdata_nx = (state_nx == S_DATA && cap_nx.wr) ? cap_nx.data : '0;
  end

  // state and capture registers
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= S_IDLE;
      cap   <= '0;
    end else begin
      state <= state_nx;
      cap   <= cap_nx;
    end
  end

  // registered outputs
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dout    <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      hbusreq <= 1'b0;
      haddr   <= '0;
      htrans  <= TR_IDLE;
      hwrite  <= 1'b0;
      hwdata  <= '0;
      slv_sel <= 2'b00;
    end else begin
      dout    <= dout_nx;
      done    <= done_nx;
      err     <= err_nx;
      busy    <= busy_nx;
      hbusreq <= hbusreq_nx;
      haddr   <= haddr_nx;
      htrans  <= htrans_nx;
      hwrite  <= hwrite_nx;
      hwdata  <= hwdata_nx;
      slv_sel <= slv_sel_nx;
    end
  end

endmodule

// File: tb/tb_ahb_master_if.sv
// Bench for ahb_master_if. A transaction-level model drives the test.
// Each transfer is described by its request and by how many cycles the
// arbiter and slave stall. The model works out which bus phase must be
// visible in every cycle, plus the dout/err values left after done.
module tb_ahb_master_if;
  logic        hclk, hresetn;
  logic [31:0] addr, din, dout, haddr, hwdata, hrdata;
  logic [1:0]  slv_sel_in, slv_sel, htrans, hresp;
  logic        wr, enable, hbusreq_in, done, err, busy, hbusreq, hgrant, hwrite, hready;
  logic [2:0]  hsize, hburst;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_dout;
  logic        exp_err;

  ahb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .hclk(hclk), .hresetn(hresetn), .addr(addr), .slv_sel_in(slv_sel_in), .din(din),
    .wr(wr), .enable(enable), .hbusreq_in(hbusreq_in), .dout(dout), .done(done),
    .err(err), .busy(busy), .hbusreq(hbusreq), .hgrant(hgrant), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .slv_sel(slv_sel), .hrdata(hrdata), .hready(hready), .hresp(hresp));

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk); #1;
  endtask

  task automatic test_reset();
    hresetn = 0; enable = 0; hbusreq_in = 0; addr = 0; din = 0; wr = 0; slv_sel_in = 0;
    hgrant = 0; hready = 1; hresp = 0; hrdata = 0;
    exp_dout = 0; exp_err = 0;
    #3;
    total++; if ({dout, haddr, hwdata} !== 96'h0) begin bad++; $display("FAIL reset_data dout=%h haddr=%h hwdata=%h want 0", dout, haddr, hwdata); end
    total++; if ({htrans, hwrite, hbusreq, done, err, busy, slv_sel} !== 9'h0) begin bad++; $display("FAIL reset_ctl got %b want 0", {htrans, hwrite, hbusreq, done, err, busy, slv_sel}); end
    total++; if ({hsize, hburst} !== 6'b010_000) begin bad++; $display("FAIL reset_const hsize=%b hburst=%b want 010 000", hsize, hburst); end
    tick(); hresetn = 1;
  endtask

  // idle cycles with no request: nothing must move
  task automatic idle_chk(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      total++; if ({done, busy, hbusreq, htrans} !== 5'b0) begin bad++; $display("FAIL idle d/b/r/t=%b want 0", {done, busy, hbusreq, htrans}); end
      total++; if ({err, dout} !== {exp_err, exp_dout}) begin bad++; $display("FAIL idle_hold err=%b dout=%h want %b %h", err, dout, exp_err, exp_dout); end
    end
  endtask

  // Called in a cycle where the DUT is in IDLE. The request is sampled at the next edge.
  // gd: cycles before an effective grant; aw/dw: address/data phase wait states.
  task automatic run_xfer(input logic [31:0] a, input logic [31:0] d, input logic w,
                          input logic [1:0] s, input int gd, input int aw, input int dw,
                          input logic [1:0] resp, input logic [31:0] rd, input logic keep,
                          input logic [31:0] junk);
    addr = a; din = d; wr = w; slv_sel_in = s; enable = 1; hbusreq_in = 1;
    hgrant = 0; hready = 1;
    tick();
    // master inputs wander mid-transfer; only the sampled values may show
    addr = junk; din = ~d; wr = ~w; slv_sel_in = ~s;
    if (!keep) begin enable = 1'($urandom); hbusreq_in = 0; end
    for (int i = 0; i <= gd; i++) begin
      total++; if ({hbusreq, htrans, busy, done} !== 5'b10010) begin bad++; $display("FAIL req_phase cyc=%0d breq/trans/busy/done=%b want 10010", i, {hbusreq, htrans, busy, done}); end
      total++; if ({err, dout, hwdata} !== {exp_err, exp_dout, 32'h0}) begin bad++; $display("FAIL req_hold err=%b dout=%h hwdata=%h want %b %h 0", err, dout, hwdata, exp_err, exp_dout); end
      if (i < gd) begin hgrant = 1'($urandom); hready = hgrant ? 1'b0 : 1'($urandom); end
      else begin hgrant = 1; hready = 1; end
      hresp = 2'($urandom); hrdata = $urandom;
      tick();
    end
    for (int k = 0; k <= aw; k++) begin
      total++; if ({htrans, hbusreq, busy, done} !== 5'b10010) begin bad++; $display("FAIL addr_phase cyc=%0d trans/breq/busy/done=%b want 10010", k, {htrans, hbusreq, busy, done}); end
      total++; if ({haddr, hwrite, slv_sel} !== {a, w, s}) begin bad++; $display("FAIL addr_ctl haddr=%h hwrite=%b slv=%b want %h %b %b", haddr, hwrite, slv_sel, a, w, s); end
      total++; if ({err, dout, hwdata} !== {exp_err, exp_dout, 32'h0}) begin bad++; $display("FAIL addr_hold err=%b dout=%h hwdata=%h want %b %h 0", err, dout, hwdata, exp_err, exp_dout); end
      hready = (k == aw); hgrant = 1'($urandom); hresp = 2'($urandom); hrdata = $urandom;
      tick();
    end
    for (int k = 0; k <= dw; k++) begin
      total++; if ({htrans, hbusreq, busy, done} !== 5'b00010) begin bad++; $display("FAIL data_phase cyc=%0d trans/breq/busy/done=%b want 00010", k, {htrans, hbusreq, busy, done}); end
      total++; if ({haddr, hwrite, slv_sel} !== {a, w, s}) begin bad++; $display("FAIL data_ctl haddr=%h hwrite=%b slv=%b want %h %b %b", haddr, hwrite, slv_sel, a, w, s); end
      total++; if (hwdata !== (w ? d : 32'h0)) begin bad++; $display("FAIL data_hwdata got %h want %h", hwdata, w ? d : 32'h0); end
      total++; if ({err, dout} !== {exp_err, exp_dout}) begin bad++; $display("FAIL data_hold err=%b dout=%h want %b %h", err, dout, exp_err, exp_dout); end
      hready = (k == dw); hgrant = 1'($urandom);
      hresp  = (k == dw) ? resp : 2'($urandom);
      hrdata = (k == dw) ? rd : $urandom;
      tick();
    end
    if (!w) exp_dout = rd;
    exp_err = (resp != 2'b00);
    total++; if ({done, busy, hbusreq, htrans} !== 5'b10000) begin bad++; $display("FAIL done_cycle done/busy/breq/trans=%b want 10000", {done, busy, hbusreq, htrans}); end
    total++; if ({err, dout} !== {exp_err, exp_dout}) begin bad++; $display("FAIL done_result err=%b dout=%h want %b %h", err, dout, exp_err, exp_dout); end
    total++; if (hwdata !== 32'h0) begin bad++; $display("FAIL done_hwdata got %h want 0", hwdata); end
    if (!keep) begin enable = 0; hbusreq_in = 0; end
    hgrant = 0; hready = 1;
  endtask

  task automatic test_reset_mid_addr();
    addr = 32'h0000_0200; din = 32'h5555_AAAA; wr = 1; slv_sel_in = 2'b10;
    enable = 1; hbusreq_in = 1; hgrant = 1; hready = 1;
    tick(); enable = 0; hbusreq_in = 0;
    tick(); hready = 0;
    total++; if ({htrans, haddr} !== {2'b10, 32'h200}) begin bad++; $display("FAIL rst_pre trans=%b haddr=%h want 10 200", htrans, haddr); end
    #2 hresetn = 0;
    #1;
    exp_dout = 0; exp_err = 0;
    total++; if ({dout, haddr, hwdata} !== 96'h0) begin bad++; $display("FAIL rst_mid_data dout=%h haddr=%h hwdata=%h want 0", dout, haddr, hwdata); end
    total++; if ({htrans, hwrite, hbusreq, done, err, busy, slv_sel} !== 9'h0) begin bad++; $display("FAIL rst_mid_ctl got %b want 0", {htrans, hwrite, hbusreq, done, err, busy, slv_sel}); end
    hready = 1;
    tick(); hresetn = 1;
    total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL rst_no_done done/busy=%b want 00", {done, busy}); end
    idle_chk(2);
  endtask

  task automatic test_single_write();
    run_xfer(32'h0000_0040, 32'hDEAD_BEEF, 1, 2'b01, 0, 0, 0, 2'b00, $urandom, 0, $urandom);
    idle_chk(2);
  endtask

  task automatic test_read_waits();
    run_xfer(32'h0000_0100, $urandom, 0, 2'b10, 0, 0, 2, 2'b00, 32'h1234_5678, 0, $urandom);
    idle_chk(2);
  endtask

  task automatic test_grant_delay();
    run_xfer(32'h0000_0300, $urandom, 0, 2'b11, 5, 1, 0, 2'b00, $urandom, 0, $urandom);
    idle_chk(1);
  endtask

  task automatic test_error_resp();
    run_xfer(32'h0000_0400, 32'hCAFE_F00D, 1, 2'b00, 0, 0, 1, 2'b01, $urandom, 0, $urandom);
    idle_chk(1);
    run_xfer(32'h0000_0404, $urandom, 0, 2'b00, 1, 0, 0, 2'b00, $urandom, 0, $urandom);
    idle_chk(1);
  endtask

  task automatic test_back_to_back();
    run_xfer(32'h0000_0040, 32'h1111_2222, 1, 2'b01, 0, 0, 0, 2'b00, $urandom, 1, 32'hFFFF_FFFF);
    run_xfer(32'h0000_0044, $urandom, 0, 2'b01, 0, 0, 0, 2'b00, 32'h3333_4444, 1, 32'hFFFF_FFFF);
    run_xfer(32'h0000_0048, $urandom, 1, 2'b10, 2, 1, 1, 2'b11, $urandom, 0, 32'hFFFF_FFFF);
    idle_chk(2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic keep;
      keep = (n == 39) ? 1'b0 : 1'($urandom);
      run_xfer($urandom, $urandom, 1'($urandom), 2'($urandom), $urandom_range(0, 4),
               $urandom_range(0, 2), $urandom_range(0, 3), 2'($urandom), $urandom, keep, $urandom);
      if (!keep) idle_chk($urandom_range(1, 3));
    end
  endtask

  initial begin
    test_reset();
    idle_chk(2);
    test_single_write();
    test_read_waits();
    test_grant_delay();
    test_error_resp();
    test_back_to_back();
    test_reset_mid_addr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_master_if.md
Name: ahb_master_if

Overview:
- Downstream of the master module: consumes its request signals (addr, slv_sel_in, din, wr, enable, hbusreq_in) and runs single AHB transfers on the shared bus.
- Arbitration: requests the bus from the arbiter and waits for grant.
- Transfer: drives the address phase, then the data phase.
- Read data returns to the master on dout.
- Each transfer is SINGLE burst, WORD size, non-pipelined: one transfer in flight.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.

Ports:
- hclk  in  1  bus/master clock, rising edge.
- hresetn  in  1  asynchronous active-low reset.
- addr  in  ADDR_WIDTH  transfer address from master.
- slv_sel_in  in  2  slave identifier from master.
- din  in  DATA_WIDTH  write data from master.
- wr  in  1  1=write, 0=read.
- enable  in  1  master enables interface.
- hbusreq_in  in  1  master bus request.
- dout  out  DATA_WIDTH  read data to master.
- done  out  1  one-cycle pulse on transfer completion.
- err  out  1  completed transfer got non-OKAY response; valid with done.
- busy  out  1  high in any state other than IDLE.
- hbusreq  out  1  bus request to arbiter.
- hgrant  in  1  grant from arbiter.
- haddr  out  ADDR_WIDTH  AHB address.
- htrans  out  2  00 IDLE, 10 NONSEQ.
- hwrite  out  1  AHB write.
- hsize  out  3  constant 3'b010.
- hburst  out  3  constant 3'b000.
- hwdata  out  DATA_WIDTH  AHB write data.
- slv_sel  out  2  slave select to decoder/mux.
- hrdata  in  DATA_WIDTH  AHB read data.
- hready  in  1  transfer-ready from slave mux.
- hresp  in  2  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.

Behaviour:
- Reset (hresetn=0, asynchronous): state=IDLE; dout, haddr, hwdata=0; htrans=00; hwrite, hbusreq, done, err, busy=0; slv_sel=00; capture registers=0.
- Constants: hsize=010 and hburst=000 at all times.
- All outputs are registered. Bus-side outputs are a function of registered state and capture registers only.

IDLE:
- htrans=00 and hbusreq=0.
- If enable && hbusreq_in is sampled, capture addr, din, wr, slv_sel_in into internal registers, then go to REQ.
- Master inputs are ignored outside IDLE. Changes mid-transfer have no effect.

REQ:
- hbusreq=1 and htrans=00.
- Stay in REQ until hgrant && hready, then go to ADDR.
- No timeout.

ADDR (address phase):
- haddr=captured addr, hwrite=captured wr, slv_sel=captured slv, htrans=10, hbusreq=0.
- Hold all of these while hready=0.
- On hready=1 go to DATA.

DATA (data phase):
- htrans=00. hwdata=captured din on writes, 0 on reads.
- haddr, hwrite and slv_sel are held.
- Hold while hready=0.
- On hready=1:
  - Reads: dout<=hrdata. Writes leave dout unchanged.
  - err<=(hresp!=00).
  - done pulses for exactly one cycle.
  - Next state is IDLE.
- Any non-OKAY response is treated as an error completion. There is no retry/split re-issue.

Timing:
- Best-case latency: request sampled at edge 0, hbusreq=1 after edge 0, NONSEQ after edge 1, data phase after edge 2, done/dout after edge 3.
- Back-to-back: if enable && hbusreq_in are still high, the next request is captured in the IDLE cycle that follows done. Minimum 4 cycles per transfer.
- err holds its last value until the next done. done is never high in two consecutive cycles.

Other rules:
- busy=1 in REQ, ADDR and DATA.
- A loss of hgrant after ADDR is entered is ignored; the current transfer completes.
- Reset mid-transfer aborts immediately to the reset values. No done pulse is produced.

Test Plan:
- Reset mid-ADDR: drive hresetn=0 while in ADDR -> all outputs reset within the same cycle; no done; after release, state=IDLE, htrans=00.
- Single write, zero wait states: addr=0x0000_0040, din=0xDEADBEEF, wr=1, slv_sel_in=01, hgrant=1, hready=1, hresp=00.
  - hbusreq=1 for 1 cycle.
  - htrans=10 with haddr=0x40, hwrite=1 for 1 cycle.
  - hwdata=0xDEADBEEF for 1 cycle.
  - done=1 with err=0, for 4 cycles total.
- Read with waits: wr=0, addr=0x100, hrdata=0x1234_5678, hready=0 for 2 cycles in the data phase.
  - DATA is held for 3 cycles.
  - dout=0x12345678 and done pulses once.
- Grant delay: hgrant held 0 for 5 cycles -> hbusreq stays 1 and htrans stays 00 for those cycles; ADDR starts the cycle after hgrant=1 is sampled.
- Error response: hresp=01 with hready=0 then 1 in the data phase -> done=1, err=1, dout unchanged, state IDLE. The next OKAY transfer clears err to 0 at its done.
- Input change during transfer: change addr to 0xFFFF_FFFF while in REQ -> haddr still shows the captured 0x40; a back-to-back request with enable held high restarts REQ in the cycle after IDLE.
